// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction-fetch slice.
package riscv_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;   // addi x0, x0, 0

   // One buffered fetch result, packed as {pc, instr, err}.
   localparam int PC_W    = XLEN;
   localparam int INSTR_W = 32;
   localparam int ERR_W   = 1;
   localparam int ENTRY_W = PC_W + INSTR_W + ERR_W;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic               err;
   } fetch_entry_t;

   // A word fetch is misaligned when either low PC bit is set.
   function automatic logic is_misaligned(input logic [1:0] pc_lo);
      return (pc_lo != 2'b00);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched words until decode takes them.
// Flush and reset both empty it at the next clock edge.
module fetch_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap freely.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage array; contents need no reset because the head is only looked at when non-empty.
   always_ff @(posedge clk) begin
      if (push && !flush && !reset) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: next-PC selection, credit-limited memory requests,
// one-entry in-flight tracking, and a FIFO feeding decode.
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc_q,
   output logic [XLEN-1:0] pc_next,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [31:0]     id_instr,
   output logic            id_err
);

   import riscv_pkg::INSTR_NOP;
   import riscv_pkg::is_misaligned;

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int OW = CW + 1;
   localparam int EW = XLEN + 33;

   logic            pop;
   logic            push;
   logic            fifo_push;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;
   logic [OW-1:0]   occupancy;
   logic            inflight_q;
   logic [XLEN-1:0] inflight_pc;
   logic            inflight_err;
   logic [EW-1:0]   push_data;
   logic [EW-1:0]   head;

   // Decode handshake: an entry transfers in any cycle where id_valid and id_ready
   // are both high; while id_valid is high and id_ready low, id_pc/id_instr/id_err
   // hold the same head entry. A redirect in the transfer cycle cancels it.
   assign id_valid = ~fifo_empty & ~reset;
   assign pop      = id_valid & id_ready;

   // Credits: entries buffered plus the one in flight may never exceed DEPTH.
   assign occupancy = OW'(fifo_count) + OW'(inflight_q) - OW'(pop);
   assign imem_req  = ~reset & ~redirect_valid & (occupancy < OW'(DEPTH));
   assign imem_addr = pc_q;

   // Next-PC priority: reset, redirect, advance on request, otherwise stall.
   always_comb begin
      pc_next = pc_q;
      if (reset)               pc_next = RESET_PC;
      else if (redirect_valid) pc_next = redirect_pc;
      else if (imem_req)       pc_next = pc_q + XLEN'(4);
   end

   // Remember the PC of the outstanding read so its data can be tagged next cycle.
   always_ff @(posedge clk) begin
      if (reset || redirect_valid) begin
         inflight_q   <= 1'b0;
         inflight_pc  <= '0;
         inflight_err <= 1'b0;
      end else begin
         inflight_q <= imem_req;
         if (imem_req) begin
            inflight_pc  <= pc_q;
            inflight_err <= is_misaligned(pc_q[1:0]);
         end
      end
   end

   // Responses arriving during a redirect or reset belong to the old stream and are dropped.
   assign push      = inflight_q & ~redirect_valid & ~reset;
   assign fifo_push = push & (~fifo_full | pop);
   assign push_data = {inflight_pc, (inflight_err ? INSTR_NOP : imem_rdata), inflight_err};

   fetch_fifo #(
      .WIDTH(EW),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (redirect_valid),
      .push  (fifo_push),
      .din   (push_data),
      .pop   (pop),
      .dout  (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Head fields read as zero whenever nothing is offered to decode.
   assign id_pc    = id_valid ? head[EW-1 -: XLEN] : '0;
   assign id_instr = id_valid ? head[32:1]          : '0;
   assign id_err   = id_valid ? head[0]             : 1'b0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized ready/redirect/reset
// traffic, checked against a queue-based model of requested-but-undelivered PCs.
module tb_fetch_unit;

   localparam int          DEPTH = 2;
   localparam logic [31:0] RST_PC = 32'h0;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc_q;
   logic [31:0] pc_next;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_err;

   int tests = 0;
   int fails = 0;

   // Reference model state.
   logic [31:0] exp_q[$];
   logic        issued_last = 1'b0;
   logic        hold_prev = 1'b0;
   logic [31:0] held_pc;
   logic [31:0] held_instr;
   logic        held_err;

   // Samples from the most recent cycle, for directed checks.
   logic        s_valid;
   logic [31:0] s_pc;
   logic [31:0] s_instr;
   logic        s_err;
   logic        s_req;
   logic [31:0] s_pcnext;
   logic [31:0] s_pcq;

   always #5 clk = ~clk;

   fetch_unit #(
      .XLEN(32),
      .RESET_PC(RST_PC),
      .DEPTH(DEPTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .pc_q           (pc_q),
      .pc_next        (pc_next),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_pc          (id_pc),
      .id_instr       (id_instr),
      .id_err         (id_err)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // PC register and synchronous instruction memory around the DUT.
   always @(posedge clk) pc_q <= pc_next;
   always @(posedge clk) if (imem_req) imem_rdata <= mem_word(imem_addr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, check, then advance the model.
   task automatic cycle(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
      logic        exp_valid;
      logic        exp_pop;
      logic        exp_req;
      logic [31:0] exp_next;
      logic [31:0] hp;
      int          ready_cnt;
      @(negedge clk);
      reset = rst;
      redirect_valid = rv;
      redirect_pc = rpc;
      id_ready = rdy;
      #1;
      s_valid = id_valid; s_pc = id_pc; s_instr = id_instr; s_err = id_err;
      s_req = imem_req; s_pcnext = pc_next; s_pcq = pc_q;

      ready_cnt = exp_q.size() - (issued_last ? 1 : 0);
      exp_valid = !rst && (ready_cnt > 0);
      exp_pop   = exp_valid && rdy;
      exp_req   = !rst && !rv && ((exp_q.size() - (exp_pop ? 1 : 0)) < DEPTH);
      if (rst)           exp_next = RST_PC;
      else if (rv)       exp_next = rpc;
      else if (exp_req)  exp_next = pc_q + 32'd4;
      else               exp_next = pc_q;

      chk("imem_addr", imem_addr, pc_q);
      chk("id_valid", id_valid, exp_valid);
      chk("imem_req", imem_req, exp_req);
      chk("pc_next", pc_next, exp_next);
      if (rst) chk("id_pc_rst", id_pc, 32'h0);

      if (hold_prev && !rst) begin
         chk("hold_pc", id_pc, held_pc);
         chk("hold_instr", id_instr, held_instr);
         chk("hold_err", id_err, held_err);
      end

      if (exp_pop && !rv) begin
         hp = exp_q.pop_front();
         chk("id_pc", id_pc, hp);
         chk("id_err", id_err, (hp[1:0] != 2'b00));
         chk("id_instr", id_instr, (hp[1:0] != 2'b00) ? NOP : mem_word(hp));
      end

      hold_prev  = exp_valid && !rdy && !rv;
      held_pc    = id_pc;
      held_instr = id_instr;
      held_err   = id_err;

      if (rst || rv) begin
         exp_q.delete();
         issued_last = 1'b0;
      end else begin
         if (exp_req) exp_q.push_back(pc_q);
         issued_last = exp_req;
      end
   endtask

   initial begin
      logic        r_rst;
      logic        r_rv;
      logic        r_rdy;
      logic [31:0] r_pc;

      // 1: reset then free-running stream from RESET_PC
      repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1);
      chk("t1_pcnext_rst", s_pcnext, RST_PC);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      chk("t1_valid_c0", s_valid, 1'b0);
      chk("t1_req_c0", s_req, 1'b1);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      chk("t1_valid_c1", s_valid, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      chk("t1_valid_c2", s_valid, 1'b1);
      chk("t1_pc_c2", s_pc, 32'h0);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      chk("t1_pc_c3", s_pc, 32'h4);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      chk("t1_pc_c4", s_pc, 32'h8);
      repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1);

      // 2: decode stalls for 6 cycles, then resumes
      repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b0);
      chk("t2_req_stalled", s_req, 1'b0);
      chk("t2_pc_held", s_pcnext, s_pcq);
      chk("t2_valid_stalled", s_valid, 1'b1);
      repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b1);

      // 3: redirect to 0x100 with the FIFO full
      repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b0);
      cycle(1'b0, 1'b1, 32'h100, 1'b1);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      chk("t3_valid_t1", s_valid, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      chk("t3_valid_t2", s_valid, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      chk("t3_valid_t3", s_valid, 1'b1);
      chk("t3_pc_t3", s_pc, 32'h100);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      chk("t3_pc_t4", s_pc, 32'h104);
      repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1);

      // 4: misaligned redirect target
      cycle(1'b0, 1'b1, 32'h102, 1'b1);
      repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1);
      chk("t4_pc", s_pc, 32'h102);
      chk("t4_err", s_err, 1'b1);
      chk("t4_instr", s_instr, NOP);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      chk("t4_pc_next_entry", s_pc, 32'h106);
      cycle(1'b0, 1'b1, 32'h40, 1'b1);
      repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b1);

      // 5: redirect coinciding with a pop and a push
      cycle(1'b0, 1'b1, 32'h200, 1'b1);
      chk("t5_valid_at_redirect", s_valid, 1'b1);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      chk("t5_valid_after", s_valid, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      chk("t5_valid_after2", s_valid, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      chk("t5_pc_t3", s_pc, 32'h200);
      repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1);

      // 6: one-cycle reset with the FIFO full
      repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b0);
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
      chk("t6_pcnext_rst", s_pcnext, RST_PC);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      chk("t6_valid_after", s_valid, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      chk("t6_valid_t3", s_valid, 1'b1);
      chk("t6_pc_t3", s_pc, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         r_rdy = ($urandom_range(0, 3) != 0);
         r_rv  = ($urandom_range(0, 15) == 0);
         r_rst = ($urandom_range(0, 79) == 0);
         r_pc  = {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
         if ($urandom_range(0, 7) == 0) r_pc[1:0] = 2'($urandom_range(1, 3));
         cycle(r_rst, r_rv, r_pc, r_rdy);
      end
      repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
